gauss_frame_sched: RTL

Frame sequencer that sits between the pixel source and the `gauss9x9` filter. It clears the filter's line buffers before each frame and forwards one frame of gray pixels under a valid/ready handshake, inserting a programmable horizontal blank after each line. It then appends zero-valued flush lines so the 9x9 window drains, and reports frame completion, a sticky sync error and the count of filtered pixels produced.

---
 rtl/gauss_pkg.sv | 26 ++
 rtl/gauss_frame_sched.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gauss_pkg.sv
// Shared types and width helpers for the gauss9x9 frame sequencer.
package gauss_pkg;

  typedef enum logic [2:0] {
    GS_IDLE,
    GS_CLEAR,
    GS_ACTIVE,
    GS_HBLANK,
    GS_FLUSH,
    GS_DONE
  } gs_state_e;

  function automatic int unsigned col_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int unsigned row_width(int unsigned height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  // Never narrower than one bit, even when flushing is disabled.
  function automatic int unsigned flush_width(int unsigned lines, int unsigned width);
    return (lines * width > 0) ? $clog2(lines * width + 1) : 1;
  endfunction

endpackage

// File: rtl/gauss_frame_sched.sv
// Frame sequencer feeding gauss9x9: clears the filter, forwards one frame with horizontal
// blanking, appends zero flush lines and reports completion, sync errors and output count.
module gauss_frame_sched
  import gauss_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned HBLANK       = 2,
  parameter int unsigned FLUSH_LINES  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_pixel_i,
  input  logic        in_sof_i,
  input  logic        in_eol_i,
  output logic        filt_rst_o,
  output logic        filt_valid_o,
  output logic [7:0]  filt_pixel_o,
  input  logic        filt_out_valid_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        sync_err_o,
  output logic [31:0] out_count_o
);

  localparam int unsigned ColW     = col_width(IMAGE_WIDTH);
  localparam int unsigned RowW     = row_width(IMAGE_HEIGHT);
  localparam int unsigned FlushLen = FLUSH_LINES * IMAGE_WIDTH;
  localparam int unsigned FlW      = flush_width(FLUSH_LINES, IMAGE_WIDTH);
  localparam int unsigned HbW      = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  gs_state_e       state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [HbW-1:0]  hb_q, hb_d;
  logic [FlW-1:0]  fl_q, fl_d;
  logic            fv_q, fv_d;
  logic [7:0]      fp_q, fp_d;
  logic            err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;

  logic xfer, last_col, last_row, first_px;

  assign last_col = (col_q == ColW'(IMAGE_WIDTH - 1));
  assign last_row = (row_q == RowW'(IMAGE_HEIGHT - 1));
  assign first_px = (col_q == '0) && (row_q == '0);
  assign xfer     = in_valid_i && (state_q == GS_ACTIVE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hb_d    = hb_q;
    fl_d    = fl_q;
    fv_d    = 1'b0;
    fp_d    = fp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if ((state_q != GS_IDLE) && filt_out_valid_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      GS_IDLE: begin
        if (start_i) begin
          state_d = GS_CLEAR;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      GS_CLEAR: begin
        col_d   = '0;
        row_d   = '0;
        state_d = GS_ACTIVE;
      end
      GS_ACTIVE: begin
        if (xfer) begin
          fv_d = 1'b1;
          fp_d = in_pixel_i;
          hb_d = '0;
          fl_d = '0;
          // Markers only flag errors; the frame geometry is fixed by the counters.
          if ((in_sof_i != first_px) || (in_eol_i != last_col)) begin
            err_d = 1'b1;
          end
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = (FLUSH_LINES == 0) ? GS_DONE : GS_FLUSH;
            end else begin
              row_d = row_q + RowW'(1);
              if (HBLANK > 0) state_d = GS_HBLANK;
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      GS_HBLANK: begin
        if (hb_q == HbW'(HBLANK - 1)) state_d = GS_ACTIVE;
        else                          hb_d    = hb_q + HbW'(1);
      end
      GS_FLUSH: begin
        fv_d = 1'b1;
        fp_d = '0;
        if (fl_q == FlW'(FlushLen - 1)) state_d = GS_DONE;
        else                            fl_d    = fl_q + FlW'(1);
      end
      GS_DONE:  state_d = GS_IDLE;
      default:  state_d = GS_IDLE;
    endcase

    if (abort_i && (state_q != GS_IDLE)) begin
      state_d = GS_IDLE;
      fv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= GS_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      hb_q    <= '0;
      fl_q    <= '0;
      fv_q    <= 1'b0;
      fp_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hb_q    <= hb_d;
      fl_q    <= fl_d;
      fv_q    <= fv_d;
      fp_q    <= fp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o   = (state_q == GS_ACTIVE);
  assign filt_rst_o   = (state_q == GS_CLEAR);
  assign busy_o       = (state_q != GS_IDLE);
  assign frame_done_o = (state_q == GS_DONE);
  assign filt_valid_o = fv_q;
  assign filt_pixel_o = fp_q;
  assign sync_err_o   = err_q;
  assign out_count_o  = cnt_q;

endmodule
